// File: rtl/seq_divider.sv
// Unsigned radix-2 restoring divider: one quotient bit per clock, WIDTH-cycle latency.
// Results are held after the single-cycle vld_out strobe until the next completion.
module seq_divider #(
    parameter int unsigned WIDTH = 59
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             abort,
    input  logic             en,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             vld_out
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CALC = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] q_sr;
    logic [WIDTH-1:0] div_reg;
    // Partial remainder is always below the divisor between iterations, so its
    // WIDTH+1-bit form only exists inside the trial subtraction below.
    logic [WIDTH-1:0] rem_reg;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;

    always_comb begin
        r_shift = {rem_reg, q_sr[WIDTH-1]};
        trial   = r_shift - {1'b0, div_reg};
        r_next  = r_shift;
        q_next  = {q_sr[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            r_next = trial;
            q_next = {q_sr[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            ready     <= 1'b1;
            vld_out   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            q_sr      <= '0;
            div_reg   <= '0;
            rem_reg   <= '0;
            cnt       <= '0;
        end else if (abort) begin
            state   <= IDLE;
            ready   <= 1'b1;
            vld_out <= 1'b0;
        end else begin
            vld_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        q_sr    <= dividend;
                        div_reg <= divisor;
                        rem_reg <= '0;
                        cnt     <= CW'(WIDTH - 1);
                        ready   <= 1'b0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    q_sr    <= q_next;
                    rem_reg <= r_next[WIDTH-1:0];
                    cnt     <= cnt - CW'(1);
                    if (cnt == '0) begin
                        quotient  <= q_next;
                        remainder <= r_next[WIDTH-1:0];
                        vld_out   <= 1'b1;
                        ready     <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: table of operand/result vectors plus hand-written
// busy, back-to-back, abort and mid-operation reset sequences.
module tb_seq_divider;

    localparam int unsigned W = 59;
    localparam int          LAT = 59;
    localparam int          TMO = 200;

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b1;
    logic         abort = 1'b0;
    logic         en = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         vld_out;

    int n_vec = 0;
    int n_err = 0;

    seq_divider #(.WIDTH(W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .abort     (abort),
        .en        (en),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .quotient  (quotient),
        .remainder (remainder),
        .vld_out   (vld_out)
    );

    always #10 sys_clk = ~sys_clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Waits (bounded) for vld_out, sampling on falling edges; returns edges elapsed.
    task automatic wait_vld(output int lat);
        lat = 0;
        while (lat < TMO) begin
            @(negedge sys_clk);
            lat++;
            if (vld_out) break;
        end
    endtask

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        @(negedge sys_clk);
        dividend = a;
        divisor  = b;
        en       = 1'b1;
        @(negedge sys_clk);
        en       = 1'b0;
        dividend = '1;
        divisor  = '1;
        wait_vld(lat);
    endtask

    logic [W-1:0] maxv;
    int           lat;
    int           bad;

    initial begin
        maxv = '1;
        tbl[0] = '{59'd100_000_000_000, 59'd100_000, 59'd1_000_000, 59'd0};
        tbl[1] = '{59'd7, 59'd2, 59'd3, 59'd1};
        tbl[2] = '{59'd5, 59'd9, 59'd0, 59'd5};
        tbl[3] = '{maxv, 59'd1, maxv, 59'd0};
        tbl[4] = '{maxv, maxv, 59'd1, 59'd0};
        tbl[5] = '{59'd0, 59'd3, 59'd0, 59'd0};
        tbl[6] = '{59'd12345, 59'd0, maxv, 59'd12345};
        tbl[7] = '{59'd1000, 59'd33, 59'd30, 59'd10};

        // Reset state, and no strobe appears without an en.
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("reset ready", W'(ready), W'(1));
        check("reset vld", W'(vld_out), W'(0));
        check("reset quotient", quotient, '0);
        check("reset remainder", remainder, '0);
        bad = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (vld_out) bad++;
        end
        check("idle spurious vld", W'(bad), W'(0));

        for (int i = 0; i < 8; i++) begin
            run_div(tbl[i].a, tbl[i].b, lat);
            check($sformatf("vec%0d latency", i), W'(lat), W'(LAT));
            check($sformatf("vec%0d quotient", i), quotient, tbl[i].q);
            check($sformatf("vec%0d remainder", i), remainder, tbl[i].r);
            check($sformatf("vec%0d ready", i), W'(ready), W'(1));
            if (i == 0) begin
                bad = 0;
                repeat (100) begin
                    @(negedge sys_clk);
                    if (vld_out || quotient !== tbl[0].q || remainder !== tbl[0].r) bad++;
                end
                check("nominal hold", W'(bad), W'(0));
            end
        end

        // Busy: en at E10 is ignored; held en then lands on the first ready edge.
        @(negedge sys_clk);
        dividend = 59'd100;
        divisor  = 59'd7;
        en       = 1'b1;
        @(negedge sys_clk);
        en = 1'b0;
        repeat (9) @(negedge sys_clk);
        check("busy ready low", W'(ready), W'(0));
        dividend = 59'd50;
        divisor  = 59'd3;
        en       = 1'b1;
        wait_vld(lat);
        check("busy latency", W'(lat + 9), W'(LAT));
        check("busy quotient", quotient, 59'd14);
        check("busy remainder", remainder, 59'd2);
        @(negedge sys_clk);
        en = 1'b0;
        check("b2b ready low", W'(ready), W'(0));
        wait_vld(lat);
        check("b2b latency", W'(lat), W'(LAT));
        check("b2b quotient", quotient, 59'd16);
        check("b2b remainder", remainder, 59'd2);

        // Abort at E30: no strobe, ready next cycle, previous result held.
        @(negedge sys_clk);
        dividend = 59'd100;
        divisor  = 59'd7;
        en       = 1'b1;
        @(negedge sys_clk);
        en = 1'b0;
        repeat (29) @(negedge sys_clk);
        abort = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0;
        check("abort ready", W'(ready), W'(1));
        check("abort vld", W'(vld_out), W'(0));
        check("abort quotient", quotient, 59'd16);
        check("abort remainder", remainder, 59'd2);
        bad = 0;
        repeat (80) begin
            @(negedge sys_clk);
            if (vld_out) bad++;
        end
        check("abort no vld", W'(bad), W'(0));

        // Reset pulse near E20: outputs clear at once, then a fresh division works.
        @(negedge sys_clk);
        dividend = 59'd100;
        divisor  = 59'd7;
        en       = 1'b1;
        @(negedge sys_clk);
        en = 1'b0;
        repeat (19) @(negedge sys_clk);
        sys_rst = 1'b1;
        #1;
        check("rst ready", W'(ready), W'(1));
        check("rst vld", W'(vld_out), W'(0));
        check("rst quotient", quotient, '0);
        check("rst remainder", remainder, '0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        run_div(59'd9, 59'd4, lat);
        check("post-rst latency", W'(lat), W'(LAT));
        check("post-rst quotient", quotient, 59'd2);
        check("post-rst remainder", remainder, 59'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle unsigned radix-2 restoring divider that serves the frequency/period measurement core. It accepts one dividend/divisor pair per `en` pulse and resolves one quotient bit per clock. It returns the quotient and remainder with a single-cycle `vld_out` strobe, then holds both values until the next result. It sits on the `sys_clk` domain directly downstream of the measurement core's `dividend`/`divisor`/`en` outputs and feeds its `quotient`/`remainder`/`vld_out`/`ready` inputs.

## Interface
- `WIDTH`, 59, operand and result width in bits; legal range 2..64.
- `sys_clk`  in  1  system clock (50 MHz); all logic is on this edge.
- `sys_rst`  in  1  asynchronous reset, active-high.
- `abort`  in  1  synchronous cancel; driven by the measurement core's synchronised refresh (`renew`) signal.
- `en`  in  1  start strobe; sampled only while `ready`=1.
- `dividend`  in  WIDTH  unsigned numerator; sampled on the accepting edge.
- `divisor`  in  WIDTH  unsigned denominator; sampled on the accepting edge.
- `ready`  out  1  1 = idle, next `en` will be accepted.
- `quotient`  out  WIDTH  result quotient; held between results.
- `remainder`  out  WIDTH  result remainder; held between results.
- `vld_out`  out  1  one-cycle strobe; `quotient`/`remainder` are valid from that cycle onward.

## Operation
- FSM states: IDLE and CALC.
- Reset (async, `sys_rst`=1):
  - State goes to IDLE.
  - `ready`=1, `vld_out`=0, `quotient`=0, `remainder`=0.
  - Internal shift and remainder registers and the bit counter clear to 0.
- IDLE:
  - `ready`=1.
  - On an edge with `en`=1 and `abort`=0: capture `dividend` into the quotient shift register and `divisor` into the divisor register, clear the partial remainder (WIDTH+1 bits), load the counter with WIDTH-1, go to CALC, and drop `ready`.
- CALC, one iteration per edge:
  - Shift: r = {r[WIDTH-1:0], q[WIDTH-1]} and q = q << 1.
  - Trial subtraction t = r - {1'b0, divisor} at WIDTH+1 bits.
  - If t is non-negative (MSB=0), set r = t and q[0]=1; otherwise set q[0]=0.
  - The counter decrements each iteration.
  - On the iteration where the counter is 0:
    - Write the final q to `quotient` and r[WIDTH-1:0] to `remainder`.
    - Pulse `vld_out`=1 for one cycle.
    - Set `ready`=1 and return to IDLE.
- Divide by zero: no special path. The algorithm naturally yields `quotient` = all ones and `remainder` = `dividend`, and latency is unchanged.
- `en` while `ready`=0 is ignored; it is neither queued nor able to corrupt the operation in flight.
- `abort`=1 on any edge:
  - State goes to IDLE and `ready`=1.
  - `vld_out` is forced to 0 on that edge.
  - `quotient` and `remainder` keep their last values.
  - `abort` takes priority over `en` and over completion on the same edge.
- Operands may change freely after the accepting edge; the divider uses only its captured copies.
- Results are exact for all unsigned inputs: dividend = quotient*divisor + remainder, with remainder < divisor whenever divisor ≠ 0.

## Timing
- Let E0 be the edge that samples `en`=1 with `ready`=1.
- Iterations occur at edges E1..E_WIDTH.
- At edge E_WIDTH, `vld_out` goes high together with the updated `quotient`/`remainder`, and `ready` also returns high. Latency is WIDTH cycles (59 at default).
- `vld_out` returns low at E_WIDTH+1 unless a new completion occurs.
- Back-to-back operation:
  - An `en` sampled at E_WIDTH (while `vld_out`=1) is accepted.
  - Throughput is one division per WIDTH cycles.
- `ready` is a registered output and is low exactly during cycles E0+..E_WIDTH−.
- Reset mid-CALC: all outputs immediately take their reset values and the in-flight result is lost.
- The consumer registers `vld_out` one cycle before reading `quotient`. This is legal because results hold until the next completion.

## Test plan
- Reset to IDLE:
  - Stimulus: hold reset, then release.
  - Required: `ready`=1, `vld_out`=0, `quotient`=0, `remainder`=0.
  - Required: no `vld_out` appears without an `en`.
- Nominal measurement division:
  - Stimulus: `dividend`=100_000_000_000 (1000×100 MHz), `divisor`=100_000, one-cycle `en`.
  - Required: `vld_out` exactly 59 cycles after the accepting edge.
  - Required: `quotient`=1_000_000, `remainder`=0, and both held for 100 further cycles.
- Remainder and edge operands:
  - 7/2 → 3 r 1.
  - 5/9 → 0 r 5.
  - (2^59−1)/1 → 2^59−1 r 0.
  - (2^59−1)/(2^59−1) → 1 r 0.
  - 0/3 → 0 r 0.
- Divide by zero:
  - Stimulus: 12345/0.
  - Required: `quotient`=2^59−1, `remainder`=12345, latency 59 cycles.
- Busy and back-to-back:
  - Stimulus: 100/7, then `en` with 50/3 at E10.
  - Required: the E10 `en` is ignored and the first result 14 r 2 is delivered.
  - Stimulus: 50/3 with `en` held so it is sampled at E_WIDTH.
  - Required: result 16 r 2 exactly 59 cycles after that edge.
- Abort and reset mid-operation:
  - Stimulus: `abort` at E30 of 100/7.
  - Required: no `vld_out`, `ready`=1 next cycle, outputs keep the previous result.
  - Stimulus: `sys_rst` pulse at E20.
  - Required: outputs show reset values at once; a following 9/4 returns 2 r 1.
